bcd_down_timer: RTL and testbench
=================================

Name: bcd_down_timer

Overview:
- Multi-digit, loadable BCD down-counter (countdown timer).
- Complements the single-digit BCD up-counter: it counts down from a BCD preset to zero instead of counting up to 9.
- Drives countdown displays and timeout logic. An external prescaler supplies `tick`, so one count happens per enabled tick.
- Contains a small control FSM (IDLE/RUN/PAUSE) with expiry and error reporting.

Parameters:
- DIGITS, 4, number of BCD digits. Counter range is 0 .. 10^DIGITS-1.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- tick  in  1  count-enable strobe, one cycle wide. Decrement happens only on a cycle with tick=1.
- load  in  1  load `preset` into the counter.
- preset  in  4*DIGITS  BCD preset. Nibble i is digit i; digit 0 is the least significant.
- start  in  1  begin or resume counting.
- pause  in  1  suspend counting.
- q  out  4*DIGITS  current BCD count, registered.
- busy  out  1  high in RUN and PAUSE.
- zero  out  1  combinational, q==0.
- expired  out  1  one-cycle pulse when the count reaches 0 from RUN.
- preset_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset: q=0, FSM=IDLE, busy=0, expired=0, preset_err=0. Because q=0, zero=1.
- FSM states:
  - IDLE: not counting.
  - RUN: decrement on each tick.
  - PAUSE: hold q.
- Per-cycle priority: load > pause > start > tick.
- load handling:
  - If every preset nibble is <=9, then q<=preset next cycle and FSM->IDLE from any state. A load during RUN aborts the run with no expired pulse.
  - If any nibble is >9, q and state are unchanged and preset_err=1 the next cycle.
- start handling:
  - IDLE->RUN if q!=0.
  - IDLE with q==0: start is ignored; stay IDLE with no pulse.
  - PAUSE->RUN.
  - Ignored in RUN.
- pause handling:
  - RUN->PAUSE.
  - Ignored in IDLE and PAUSE.
  - A tick on the same cycle as pause is not counted.
- Decrement in RUN with tick=1:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit. A borrow ripples combinationally within the same cycle.
  - Example: 1000 -> 0999 in one tick.
- Expiry:
  - A RUN decrement that produces q==0 gives q=0, FSM->IDLE and expired=1 on that same edge. expired is registered and lasts one cycle.
  - No wrap below 0: the counter never goes from 0 to 9..9.
- Latency:
  - All outputs update on the clk edge after the qualifying input; there are no extra pipeline stages.
  - zero follows q combinationally.
- busy = (state==RUN || state==PAUSE), registered via the state encoding.
- tick outside RUN has no effect.
- Asynchronous reset mid-run: immediate return to reset values; no expired pulse.
- Digit values stay within 0..9 at all times. Any non-BCD digit state is unreachable.

Decomposition:
- Shared package (bcd_pkg):
  - FSM state typedef {IDLE, RUN, PAUSE}.
  - Constant BCD_MAX=4'd9.
  - Function is_bcd(nibble).
- Sub-module bcd_down_digit, instantiated DIGITS times in a generate loop. Per digit:
  - Inputs: clk, reset_n, ld, d[3:0], dec.
  - Outputs: q[3:0], borrow_out = dec && q==0.
  - Digit i+1 dec = digit i borrow_out.
- Top level holds:
  - FSM.
  - Preset validation.
  - Expiry detection: all digits 0 after the decrement, i.e. next-q==0.
  - Output registers.

Test Plan:
- Reset, then load preset=16'h0003, start, tick every cycle: q sequence 0003, 0002, 0001, 0000. expired=1 exactly once on the 0000 edge; busy=0 afterward.
- Borrow ripple: load 16'h1000, start, one tick -> q=16'h0999. A further tick -> 16'h0998.
- Pause/resume: load 0005, start, 2 ticks (q=0003). Pause asserted with tick -> q stays 0003 through 5 ticks in PAUSE. start -> RUN, 3 ticks -> 0000 and expired pulse.
- Invalid preset: load 16'h12A4 while q=0007 -> q stays 0007, preset_err pulses one cycle, state unchanged.
- Edge controls: start with q=0000 -> stays IDLE, busy=0, no expired. load 0009 while RUN at 0004 -> q=0009, IDLE, no expired. load+pause+start on the same cycle -> load wins.
- Async reset mid-run at q=0042 -> q=0000 and busy=0 immediately, with no expired pulse at any point.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// No logic of its own; imported by the timer top and its digit cells.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: loads, or decrements with 0 -> 9 wrap.
// Registered count, one-cycle update; borrow_out is combinational. No backpressure.
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ld,
  input  logic [3:0] d,
  input  logic       dec,
  output logic [3:0] q,
  output logic       borrow_out
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec && (q_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer with IDLE/RUN/PAUSE control.
// Every output updates on the edge after the qualifying input; zero is combinational. No backpressure.
module bcd_down_timer
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   q,
  output logic                  busy,
  output logic                  zero,
  output logic                  expired,
  output logic                  preset_err
);

  localparam logic [4*DIGITS-1:0] Q_ONE = {{(4*DIGITS-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic                expired_q, expired_d;
  logic                preset_err_q, preset_err_d;
  logic                preset_ok;
  logic                ld;
  logic                dec;
  logic [DIGITS:0]     dec_chain;
  logic [4*DIGITS-1:0] q_w;

  always_comb begin
    preset_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd(preset[4*i +: 4])) begin
        preset_ok = 1'b0;
      end
    end
  end

  // A load, valid or not, consumes the cycle: no other control or tick acts.
  always_comb begin
    state_d      = state_q;
    ld           = 1'b0;
    dec          = 1'b0;
    expired_d    = 1'b0;
    preset_err_d = 1'b0;
    if (load) begin
      if (preset_ok) begin
        ld      = 1'b1;
        state_d = IDLE;
      end else begin
        preset_err_d = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick && !zero) begin
            dec = 1'b1;
            // Count of one goes to zero on this edge; the top-digit borrow
            // term keeps an impossible underflow from reading as expiry.
            if (q_w == Q_ONE && !dec_chain[DIGITS]) begin
              state_d   = IDLE;
              expired_d = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        default: begin
          if (start && !pause && !zero) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  assign dec_chain[0] = dec;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_down_digit u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .ld         (ld),
      .d          (preset[4*i +: 4]),
      .dec        (dec_chain[i]),
      .q          (q_w[4*i +: 4]),
      .borrow_out (dec_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      expired_q    <= 1'b0;
      preset_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      expired_q    <= expired_d;
      preset_err_q <= preset_err_d;
    end
  end

  assign q          = q_w;
  assign zero       = (q_w == '0);
  assign busy       = (state_q == RUN) || (state_q == PAUSE);
  assign expired    = expired_q;
  assign preset_err = preset_err_q;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Randomized scoreboard bench for bcd_down_timer against a decimal-integer reference model.
module tb_bcd_down_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = 16'h0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] q;
  logic        busy, zero, expired, preset_err;

  bcd_down_timer #(.DIGITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .load       (load),
    .preset     (preset),
    .start      (start),
    .pause      (pause),
    .q          (q),
    .busy       (busy),
    .zero       (zero),
    .expired    (expired),
    .preset_err (preset_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic        busy;
    logic        zero;
    logic        expired;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: plain decimal count and a mode (0 idle, 1 running, 2 paused).
  int m_cnt  = 0;
  int m_mode = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = 16'h0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_valid(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      if (p[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] p);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(p[4*i +: 4]);
    return v;
  endfunction

  task automatic step(input logic t, input logic ld, input logic [15:0] p,
                      input logic st, input logic ps);
    exp_t e;
    @(negedge clk);
    tick = t; load = ld; preset = p; start = st; pause = ps;
    e.expired = 1'b0;
    e.err     = 1'b0;
    if (ld) begin
      if (bcd_valid(p)) begin
        m_cnt  = from_bcd(p);
        m_mode = 0;
      end else begin
        e.err = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (ps) begin
        m_mode = 2;
      end else if (t && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_mode    = 0;
          e.expired = 1'b1;
        end
      end
    end else if (m_mode == 2) begin
      if (st && !ps) m_mode = 1;
    end else begin
      if (st && !ps && m_cnt != 0) m_mode = 1;
    end
    e.q    = to_bcd(m_cnt);
    e.busy = (m_mode != 0);
    e.zero = (m_cnt == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [15:0] eq,
                           input logic ebusy, input logic ezero);
    vectors++;
    if (q !== eq || busy !== ebusy || zero !== ezero || expired !== 1'b0 || preset_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b zero=%b expired=%b err=%b, want q=%h busy=%b zero=%b expired=0 err=0",
               name, q, busy, zero, expired, preset_err, eq, ebusy, ezero);
    end
  endtask

  // Monitor: compares every registered result just after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (q !== e.q || busy !== e.busy || zero !== e.zero ||
          expired !== e.expired || preset_err !== e.err) begin
        miscompares++;
        $display("FAIL cycle %0t: got q=%h busy=%b zero=%b expired=%b err=%b, want q=%h busy=%b zero=%b expired=%b err=%b",
                 $time, q, busy, zero, expired, preset_err,
                 e.q, e.busy, e.zero, e.expired, e.err);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    check_now("reset_state", 16'h0000, 1'b0, 1'b1);
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    // Countdown to expiry, then one tick while idle.
    step(1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(4);

    // Borrow ripple across three digits.
    step(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(2);

    // Pause with a same-cycle tick, hold, resume to expiry.
    step(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(2);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    ticks(5);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(3);

    // Rejected preset leaves count and state alone.
    step(1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h12A4, 1'b0, 1'b0);
    idle(1);

    // Start on zero is ignored; load aborts a run; load beats pause and start.
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'h0008, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(4);
    step(1'b1, 1'b1, 16'h0009, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0021, 1'b1, 1'b1);
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] p;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)      p = to_bcd($urandom_range(0, 30));
      else if (sel == 1) p = to_bcd($urandom_range(0, 9999));
      else               p = 16'($urandom);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0), p,
           1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 12) == 0));
    end

    // Asynchronous reset in the middle of a run.
    step(1'b0, 1'b1, 16'h0045, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    ticks(3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    m_cnt  = 0;
    m_mode = 0;
    #1;
    check_now("async_reset_mid_run", 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_now("held_in_reset", 16'h0000, 1'b0, 1'b1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected results never observed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
